// File: rtl/ppcmd_pkg.sv
// Shared widths, defaults and read-tag types for the pulse-program command memory port B.
package ppcmd_pkg;

  localparam int PPCMD_ADDR_W     = 12;
  localparam int PPCMD_DATA_W     = 32;
  localparam int PPCMD_RD_LAT     = 2;
  localparam int PPCMD_STARVE_MAX = 4;

  typedef enum logic {
    OWN_SEQ  = 1'b0,
    OWN_HOST = 1'b1
  } owner_e;

  // One in-flight read slot: which requester receives the returning word.
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/ppcmd_portb_arbiter_if.sv
// Requester and port B signal bundle; slave is the arbiter view, master the surroundings.
interface ppcmd_portb_arbiter_if
  import ppcmd_pkg::*;
#(
  parameter int ADDR_W = PPCMD_ADDR_W,
  parameter int DATA_W = PPCMD_DATA_W
);

  logic              seq_req;
  logic [ADDR_W-1:0] seq_addr;
  logic              seq_gnt;
  logic [DATA_W-1:0] seq_rdata;
  logic              seq_rvalid;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport slave (
    input  seq_req, seq_addr,
    output seq_gnt, seq_rdata, seq_rvalid,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rdata, host_rvalid,
    output mem_we, mem_addr, mem_din,
    input  mem_dout
  );

  modport master (
    output seq_req, seq_addr,
    input  seq_gnt, seq_rdata, seq_rvalid,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rdata, host_rvalid,
    input  mem_we, mem_addr, mem_din,
    output mem_dout
  );

endinterface

// File: rtl/ppcmd_rd_tag_pipe.sv
// Shift register of {valid, owner} tags, aligned so the last stage coincides with mem_dout.
module ppcmd_rd_tag_pipe
  import ppcmd_pkg::*;
#(
  parameter int DEPTH = PPCMD_RD_LAT + 1
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t [DEPTH-1:0] stage;

  // NOTE: the tag stages are cleared on reset because their valid bits decide whether a
  // returning word is delivered; the data path itself needs no such clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[DEPTH-2:0], tag_in};
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/ppcmd_portb_arbiter.sv
// Port B arbiter: fixed sequencer priority with a host starvation bound, registered issue, tagged read return.
module ppcmd_portb_arbiter
  import ppcmd_pkg::*;
#(
  parameter int ADDR_W     = PPCMD_ADDR_W,
  parameter int DATA_W     = PPCMD_DATA_W,
  parameter int RD_LAT     = PPCMD_RD_LAT,
  parameter int STARVE_MAX = PPCMD_STARVE_MAX
) (
  input logic                 clk,
  input logic                 rst_n,
  ppcmd_portb_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0]  starve_cnt;
  logic              seq_gnt;
  logic              host_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic              seq_rvalid;
  logic              host_rvalid;
  logic [DATA_W-1:0] seq_rdata;
  logic [DATA_W-1:0] host_rdata;
  rd_tag_t           tag_in;
  rd_tag_t           tag_out;

  // Grants are held low during reset so every output reads 0 while rst_n is asserted.
  // NOTE: both grants get a default before any branch; without it a path that skips an
  // assignment would make the synthesiser keep the old value in a latch.
  always_comb begin
    seq_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst_n) begin
      if (bus.seq_req && !(bus.host_req && starve_cnt == CNT_MAX)) begin
        seq_gnt = 1'b1;
      end else if (bus.host_req) begin
        host_gnt = 1'b1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values,
  // independent of statement order in the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
    end else begin
      if (!bus.host_req || host_gnt) begin
        starve_cnt <= '0;
      end else if (seq_gnt && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end

      mem_we <= host_gnt && bus.host_we;
      if (seq_gnt) begin
        mem_addr <= bus.seq_addr;
      end else if (host_gnt) begin
        mem_addr <= bus.host_addr;
      end
      if (host_gnt && bus.host_we) begin
        mem_din <= bus.host_wdata;
      end
    end
  end

  // Writes enter the pipe as bubbles so they never produce an rvalid.
  always_comb begin
    tag_in.valid = seq_gnt || (host_gnt && !bus.host_we);
    tag_in.owner = host_gnt ? OWN_HOST : OWN_SEQ;
  end

  ppcmd_rd_tag_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  // The non-owner's rdata keeps its last word; only the owner's register loads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_rvalid  <= 1'b0;
      host_rvalid <= 1'b0;
      seq_rdata   <= '0;
      host_rdata  <= '0;
    end else begin
      seq_rvalid  <= tag_out.valid && tag_out.owner == OWN_SEQ;
      host_rvalid <= tag_out.valid && tag_out.owner == OWN_HOST;
      if (tag_out.valid && tag_out.owner == OWN_SEQ) begin
        seq_rdata <= bus.mem_dout;
      end
      if (tag_out.valid && tag_out.owner == OWN_HOST) begin
        host_rdata <= bus.mem_dout;
      end
    end
  end

  assign bus.seq_gnt     = seq_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_din     = mem_din;
  assign bus.seq_rvalid  = seq_rvalid;
  assign bus.host_rvalid = host_rvalid;
  assign bus.seq_rdata   = seq_rdata;
  assign bus.host_rdata  = host_rdata;

endmodule

// File: tb/tb_ppcmd_portb_arbiter.sv
// Scoreboard bench: three arbiters (RD_LAT 2, 1, 4) share stimulus; each has its own port B model.
module tb_ppcmd_portb_arbiter;
  import ppcmd_pkg::*;

  localparam int AW    = PPCMD_ADDR_W;
  localparam int DW    = PPCMD_DATA_W;
  localparam int LAT_A = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          seq_req = 1'b0;
  logic [AW-1:0] seq_addr = '0;
  logic          host_req = 1'b0;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [DW-1:0] host_wdata = '0;

  always #5 clk = ~clk;

  ppcmd_portb_arbiter_if bus_a ();
  ppcmd_portb_arbiter_if bus_b ();
  ppcmd_portb_arbiter_if bus_c ();

  assign bus_a.seq_req = seq_req;   assign bus_b.seq_req = seq_req;   assign bus_c.seq_req = seq_req;
  assign bus_a.seq_addr = seq_addr; assign bus_b.seq_addr = seq_addr; assign bus_c.seq_addr = seq_addr;
  assign bus_a.host_req = host_req; assign bus_b.host_req = host_req; assign bus_c.host_req = host_req;
  assign bus_a.host_we = host_we;   assign bus_b.host_we = host_we;   assign bus_c.host_we = host_we;
  assign bus_a.host_addr = host_addr;   assign bus_b.host_addr = host_addr;   assign bus_c.host_addr = host_addr;
  assign bus_a.host_wdata = host_wdata; assign bus_b.host_wdata = host_wdata; assign bus_c.host_wdata = host_wdata;

  ppcmd_portb_arbiter #(.RD_LAT(LAT_A)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  ppcmd_portb_arbiter #(.RD_LAT(1))     u_dut_1 (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  ppcmd_portb_arbiter #(.RD_LAT(4))     u_dut_4 (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  // Port B model: write-first RAM with RD_LAT output registers per instance.
  logic [DW-1:0] ram    [1<<AW];
  logic [DW-1:0] shadow [1<<AW];
  logic [DW-1:0] pa [2];
  logic [DW-1:0] pb;
  logic [DW-1:0] pc [4];

  function automatic logic [DW-1:0] ram_rd(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    return we ? d : ram[a];
  endfunction

  always @(posedge clk) begin
    if (bus_a.mem_we) ram[bus_a.mem_addr] <= bus_a.mem_din;
    pa[0] <= ram_rd(bus_a.mem_we, bus_a.mem_addr, bus_a.mem_din);
    pa[1] <= pa[0];
    pb    <= ram_rd(bus_b.mem_we, bus_b.mem_addr, bus_b.mem_din);
    pc[0] <= ram_rd(bus_c.mem_we, bus_c.mem_addr, bus_c.mem_din);
    for (int i = 1; i < 4; i++) pc[i] <= pc[i-1];
  end

  assign bus_a.mem_dout = pa[1];
  assign bus_b.mem_dout = pb;
  assign bus_c.mem_dout = pc[3];

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t seq_q[$];
  exp_t host_q[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  logic last_seq_gnt = 1'b0;
  logic last_host_gnt = 1'b0;

  // Records this cycle's grants into the scoreboard, advances one clock, then checks returns.
  task automatic tick();
    exp_t e;
    #1;
    last_seq_gnt  = bus_a.seq_gnt;
    last_host_gnt = bus_a.host_gnt;
    total++;
    if (bus_a.seq_gnt && bus_a.host_gnt) begin
      bad++;
      $display("FAIL one_grant cycle=%0d got seq_gnt=1 host_gnt=1 want at most one", cycle);
    end
    if (bus_a.seq_gnt) seq_q.push_back('{shadow[seq_addr], cycle + 2 + LAT_A});
    if (bus_a.host_gnt) begin
      if (host_we) shadow[host_addr] = host_wdata;
      else host_q.push_back('{shadow[host_addr], cycle + 2 + LAT_A});
    end
    @(posedge clk);
    cycle++;
    #1;
    if (bus_a.seq_rvalid) begin
      total++;
      if (seq_q.size() == 0) begin
        bad++;
        $display("FAIL seq_return cycle=%0d got unexpected rvalid data=%h want none", cycle, bus_a.seq_rdata);
      end else begin
        e = seq_q.pop_front();
        if (bus_a.seq_rdata !== e.data || cycle != e.due) begin
          bad++;
          $display("FAIL seq_return got data=%h cycle=%0d want data=%h cycle=%0d", bus_a.seq_rdata, cycle, e.data, e.due);
        end
      end
    end
    if (seq_q.size() > 0 && seq_q[0].due < cycle) begin
      total++; bad++;
      $display("FAIL seq_return got no rvalid by cycle=%0d want data=%h at cycle=%0d", cycle, seq_q[0].data, seq_q[0].due);
      seq_q.delete(0);
    end
    if (bus_a.host_rvalid) begin
      total++;
      if (host_q.size() == 0) begin
        bad++;
        $display("FAIL host_return cycle=%0d got unexpected rvalid data=%h want none", cycle, bus_a.host_rdata);
      end else begin
        e = host_q.pop_front();
        if (bus_a.host_rdata !== e.data || cycle != e.due) begin
          bad++;
          $display("FAIL host_return got data=%h cycle=%0d want data=%h cycle=%0d", bus_a.host_rdata, cycle, e.data, e.due);
        end
      end
    end
    if (host_q.size() > 0 && host_q[0].due < cycle) begin
      total++; bad++;
      $display("FAIL host_return got no rvalid by cycle=%0d want data=%h at cycle=%0d", cycle, host_q[0].data, host_q[0].due);
      host_q.delete(0);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((seq_q.size() > 0 || host_q.size() > 0) && n < 12) begin
      tick();
      n++;
    end
    total++;
    if (seq_q.size() > 0 || host_q.size() > 0) begin
      bad++;
      $display("FAIL drain got %0d pending returns want 0", seq_q.size() + host_q.size());
      seq_q.delete();
      host_q.delete();
    end
  endtask

  task automatic test_reset();
    seq_req = 1'b1;
    #1;
    total++;
    if ({bus_a.seq_gnt, bus_a.host_gnt, bus_a.seq_rvalid, bus_a.host_rvalid, bus_a.mem_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 00000", {bus_a.seq_gnt, bus_a.host_gnt, bus_a.seq_rvalid, bus_a.host_rvalid, bus_a.mem_we});
    end
    total++;
    if (bus_a.mem_addr !== '0 || bus_a.mem_din !== '0) begin
      bad++;
      $display("FAIL reset_mem got addr=%h din=%h want 0", bus_a.mem_addr, bus_a.mem_din);
    end
    total++;
    if (bus_a.seq_rdata !== '0 || bus_a.host_rdata !== '0) begin
      bad++;
      $display("FAIL reset_rdata got seq=%h host=%h want 0", bus_a.seq_rdata, bus_a.host_rdata);
    end
    seq_req = 1'b0;
    rst_n   = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_seq_read();
    logic [AW-1:0] addrs [2];
    addrs[0] = 12'h005;
    addrs[1] = 12'hFFF;
    for (int i = 0; i < 2; i++) begin
      seq_addr = addrs[i];
      seq_req  = 1'b1;
      #1;
      total++;
      if (bus_a.seq_gnt !== 1'b1 || bus_a.host_gnt !== 1'b0) begin
        bad++;
        $display("FAIL seq_gnt got seq=%b host=%b want seq=1 host=0", bus_a.seq_gnt, bus_a.host_gnt);
      end
      tick();
      seq_req = 1'b0;
      total++;
      if (bus_a.mem_addr !== addrs[i] || bus_a.mem_we !== 1'b0) begin
        bad++;
        $display("FAIL seq_issue got addr=%h we=%b want addr=%h we=0", bus_a.mem_addr, bus_a.mem_we, addrs[i]);
      end
      drain();
    end
  endtask

  task automatic test_host_wr_rd();
    host_req = 1'b1; host_we = 1'b1; host_addr = 12'h7FF; host_wdata = 32'hDEAD_BEEF;
    tick();
    total++;
    if (last_host_gnt !== 1'b1) begin
      bad++;
      $display("FAIL host_wr_gnt got %b want 1", last_host_gnt);
    end
    host_we = 1'b0;
    total++;
    if (bus_a.mem_we !== 1'b1 || bus_a.mem_addr !== 12'h7FF || bus_a.mem_din !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL host_wr_issue got we=%b addr=%h din=%h want we=1 addr=7ff din=deadbeef", bus_a.mem_we, bus_a.mem_addr, bus_a.mem_din);
    end
    tick();
    host_req = 1'b0;
    total++;
    if (last_host_gnt !== 1'b1 || bus_a.mem_we !== 1'b0 || bus_a.mem_addr !== 12'h7FF) begin
      bad++;
      $display("FAIL host_rd_issue got gnt=%b we=%b addr=%h want gnt=1 we=0 addr=7ff", last_host_gnt, bus_a.mem_we, bus_a.mem_addr);
    end
    drain();
  endtask

  task automatic test_contention();
    logic want_host;
    seq_req = 1'b1; host_req = 1'b1; host_we = 1'b0;
    for (int k = 0; k < 15; k++) begin
      seq_addr  = AW'(32'h100 + k);
      host_addr = AW'(32'h200 + k);
      want_host = (k % 5 == 4);
      tick();
      total++;
      if ({last_seq_gnt, last_host_gnt} !== {!want_host, want_host}) begin
        bad++;
        $display("FAIL contention k=%0d got seq=%b host=%b want seq=%b host=%b", k, last_seq_gnt, last_host_gnt, !want_host, want_host);
      end
    end
    seq_req = 1'b0; host_req = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    seq_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seq_addr = AW'(i);
      tick();
      total++;
      if (last_seq_gnt !== 1'b1) begin
        bad++;
        $display("FAIL b2b_gnt i=%0d got %b want 1", i, last_seq_gnt);
      end
    end
    seq_req = 1'b0;
    drain();
  endtask

  task automatic test_reset_midop();
    seq_req = 1'b1;
    seq_addr = 12'h010;
    tick();
    seq_addr = 12'h011;
    tick();
    seq_req = 1'b0;
    rst_n = 1'b0;
    seq_q.delete();
    host_q.delete();
    #1;
    total++;
    if ({bus_a.seq_rvalid, bus_a.host_rvalid, bus_a.mem_we} !== 3'b0 || bus_a.mem_addr !== '0 || bus_a.seq_rdata !== '0) begin
      bad++;
      $display("FAIL midop_reset got rvalid=%b%b we=%b addr=%h rdata=%h want 0", bus_a.seq_rvalid, bus_a.host_rvalid, bus_a.mem_we, bus_a.mem_addr, bus_a.seq_rdata);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    seq_req = 1'b1;
    seq_addr = 12'h005;
    tick();
    seq_req = 1'b0;
    drain();
  endtask

  task automatic test_rd_lat_sweep();
    int g;
    int got_b = -1;
    int got_c = -1;
    logic [DW-1:0] data_b = '0;
    logic [DW-1:0] data_c = '0;
    logic [DW-1:0] want;
    repeat (4) tick();
    seq_addr = 12'h0AB;
    want = shadow[12'h0AB];
    seq_req = 1'b1;
    g = cycle;
    tick();
    seq_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_b.seq_rvalid && got_b < 0) begin got_b = cycle; data_b = bus_b.seq_rdata; end
      if (bus_c.seq_rvalid && got_c < 0) begin got_c = cycle; data_c = bus_c.seq_rdata; end
    end
    total++;
    if (got_b != g + 3 || data_b !== want) begin
      bad++;
      $display("FAIL rd_lat1 got cycle=%0d data=%h want cycle=%0d data=%h", got_b, data_b, g + 3, want);
    end
    total++;
    if (got_c != g + 6 || data_c !== want) begin
      bad++;
      $display("FAIL rd_lat4 got cycle=%0d data=%h want cycle=%0d data=%h", got_c, data_c, g + 6, want);
    end
    drain();
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]    = 32'hC300_0000 ^ (i * 32'h0001_0003);
      shadow[i] = 32'hC300_0000 ^ (i * 32'h0001_0003);
    end
    ram[5]    = 32'h0123_4567;
    shadow[5] = 32'h0123_4567;
    repeat (2) @(posedge clk);
    test_reset();
    test_seq_read();
    test_host_wr_rd();
    test_contention();
    test_back_to_back();
    test_reset_midop();
    test_rd_lat_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog");
  end

endmodule
